// File: rtl/ila_buffer_reader_pkg.sv
// Shared state encoding and credit helper for the ILA sample-buffer read-out engine.
package ila_buffer_reader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        DRAIN = ST_DRAIN
    } state_e;

    localparam int FIFO_DEPTH = 2;

    // Samples that will sit in the output FIFO next cycle must stay below its depth.
    function automatic logic hasCredit(input logic [1:0] occ,
                                       input logic       inFlight,
                                       input logic       pop);
        logic [2:0] pending;
        pending = {1'b0, occ} + {2'b00, inFlight} - {2'b00, pop};
        return pending < 3'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/ila_buffer_reader_skid_fifo.sv
// Two-entry FIFO holding {last, data} between the sample RAM and the output stream.
module ila_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [1:0]       occ_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wrPtr_q;
    logic             wrPtr_d;
    logic             rdPtr_q;
    logic             rdPtr_d;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic             doPop;

    always_comb begin
        doPop   = pop_i && (occ_q != 2'd0);
        wrPtr_d = wrPtr_q ^ push_i;
        rdPtr_d = rdPtr_q ^ doPop;
        occ_d   = occ_q;
        if (push_i && !doPop) begin
            occ_d = occ_q + 2'd1;
        end else if (!push_i && doPop) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            occ_q   <= occ_d;
        end
    end

    // Storage is cleared on reset so the exposed head reads as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push_i) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign occ_o   = occ_q;

endmodule

// File: rtl/ila_buffer_reader.sv
// Reads a wrapping window out of the circular ILA sample RAM and streams it out valid/ready.
module ila_buffer_reader
    import ila_buffer_reader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   count_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_ren_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o
);

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic [ADDR_W:0]   issueCnt_q;
    logic [ADDR_W:0]   issueCnt_d;
    logic [ADDR_W:0]   deliverCnt_q;
    logic [ADDR_W:0]   deliverCnt_d;
    logic              inFlight_q;
    logic              done_q;
    logic              done_d;
    logic              memRen;

    logic              fifoPush;
    logic              fifoPop;
    logic              pushLast;
    logic [DATA_W:0]   fifoHead;
    logic [1:0]        fifoOcc;

    // Only data belonging to a read issued last cycle is ever captured.
    assign fifoPush = inFlight_q;
    assign pushLast = (deliverCnt_q == (count_q - CNT_ONE));
    assign valid_o  = (fifoOcc != 2'd0);
    assign fifoPop  = valid_o && ready_i;

    ila_skid_fifo #(
        .WIDTH(DATA_W + 1)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (fifoPush),
        .wdata_i({pushLast, mem_rdata_i}),
        .pop_i  (fifoPop),
        .rdata_o(fifoHead),
        .occ_o  (fifoOcc)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        issueCnt_d   = issueCnt_q;
        deliverCnt_d = deliverCnt_q;
        done_d       = 1'b0;
        memRen       = 1'b0;

        if (fifoPush) begin
            deliverCnt_d = deliverCnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d       = base_addr_i;
                    count_d      = count_i;
                    issueCnt_d   = '0;
                    deliverCnt_d = '0;
                    if (count_i != '0) begin
                        state_d = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (hasCredit(fifoOcc, inFlight_q, fifoPop)) begin
                    memRen     = 1'b1;
                    addr_d     = addr_q + ADDR_ONE;
                    issueCnt_d = issueCnt_q + CNT_ONE;
                    if (issueCnt_d == count_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Handing off the tagged final beat is what ends the window.
                if (fifoPop && fifoHead[DATA_W]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            count_q      <= '0;
            issueCnt_q   <= '0;
            deliverCnt_q <= '0;
            inFlight_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            issueCnt_q   <= issueCnt_d;
            deliverCnt_q <= deliverCnt_d;
            inFlight_q   <= memRen;
            done_q       <= done_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign mem_ren_o  = memRen;
    assign mem_addr_o = addr_q;
    assign data_o     = fifoHead[DATA_W-1:0];
    assign last_o     = fifoHead[DATA_W];

endmodule

// File: tb/tb_ila_buffer_reader.sv
// Self-checking bench for ila_buffer_reader: RAM model, read/beat scoreboard, cycle-exact corner sequences.
module tb_ila_buffer_reader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] baseAddr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              memRen;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memRdata;
    logic [DATA_W-1:0] dataOut;
    logic              valid;
    logic              ready;
    logic              last;

    int vecCount  = 0;
    int missCount = 0;
    int lastCount = 0;

    logic [ADDR_W-1:0] addrQ [$];
    logic [DATA_W:0]   beatQ [$];

    logic [15:0] vMask;
    logic [15:0] lMask;
    logic [15:0] rMask;
    logic [15:0] bMask;
    logic [15:0] dMask;
    logic [DATA_W-1:0] dataLog [16];

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   cnt;
        bit                randReady;
        int                expDone;
    } vec_t;

    vec_t vecs [7];

    ila_buffer_reader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .base_addr_i(baseAddr),
        .count_i    (count),
        .busy_o     (busy),
        .done_o     (done),
        .mem_ren_o  (memRen),
        .mem_addr_o (memAddr),
        .mem_rdata_i(memRdata),
        .data_o     (dataOut),
        .valid_o    (valid),
        .ready_i    (ready),
        .last_o     (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] sampleAt(input logic [ADDR_W-1:0] a);
        return {6'h2A, a, 6'h15, ~a};
    endfunction

    // Synchronous-read RAM; garbage appears whenever no read was issued.
    always @(posedge clk) begin
        memRdata <= memRen ? sampleAt(memAddr) : 32'hBAD0_BAD0;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a start for one cycle and queues the addresses and beats it must produce.
    task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
        logic [ADDR_W-1:0] a;
        start     = 1'b1;
        baseAddr  = b;
        count     = n;
        lastCount = 0;
        for (int i = 0; i < int'(n); i++) begin
            a = b + ADDR_W'(i);
            addrQ.push_back(a);
            beatQ.push_back({(i == int'(n) - 1), sampleAt(a)});
        end
        tick();
        start = 1'b0;
    endtask

    task automatic sampleCycles(input int n, input int riseCycle, input int restartCycle);
        vMask = '0; lMask = '0; rMask = '0; bMask = '0; dMask = '0;
        for (int k = 1; k <= n; k++) begin
            ready = (k >= riseCycle);
            if (k == restartCycle) begin
                start    = 1'b1;
                baseAddr = 10'd7;
                count    = 11'd2;
            end else begin
                start = 1'b0;
            end
            #1;
            vMask[k]   = valid;
            lMask[k]   = valid && last;
            rMask[k]   = memRen;
            bMask[k]   = busy;
            dMask[k]   = done;
            dataLog[k] = dataOut;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic runWindow(input logic [ADDR_W:0] n, input bit randReady, input int expDone);
        int cyc;
        cyc = 1;
        while (!done && cyc < 5000) begin
            ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
        end
        ready = 1'b1;
        checkOutput("window done seen", done, 1'b1);
        if (expDone >= 0) checkOutput("window done cycle", cyc, expDone);
        checkOutput("window beats left", beatQ.size(), 0);
        checkOutput("window reads left", addrQ.size(), 0);
        checkOutput("window last count", lastCount, (n != 0) ? 1 : 0);
    endtask

    // Scoreboard: every read address and every accepted beat is matched against the queues.
    always @(negedge clk) begin
        logic [DATA_W:0] exp;
        if (memRen) begin
            if (addrQ.size() == 0) checkOutput("unexpected read", memAddr, 64'hFFFF);
            else checkOutput("read address", memAddr, addrQ.pop_front());
        end
        if (valid && ready) begin
            if (last) lastCount++;
            if (beatQ.size() == 0) begin
                checkOutput("unexpected beat", dataOut, 64'hFFFF_FFFF_FFFF);
            end else begin
                exp = beatQ.pop_front();
                checkOutput("beat data", dataOut, exp[DATA_W-1:0]);
                checkOutput("beat last", last, exp[DATA_W]);
            end
        end
    end

    initial begin
        vecs[0] = '{base: 10'd0,    cnt: 11'd1,    randReady: 1'b0, expDone: 4};
        vecs[1] = '{base: 10'd512,  cnt: 11'd2,    randReady: 1'b0, expDone: 5};
        vecs[2] = '{base: 10'd1023, cnt: 11'd3,    randReady: 1'b0, expDone: 6};
        vecs[3] = '{base: 10'd1000, cnt: 11'd40,   randReady: 1'b1, expDone: -1};
        vecs[4] = '{base: 10'd0,    cnt: 11'd1024, randReady: 1'b0, expDone: 1027};
        vecs[5] = '{base: 10'd7,    cnt: 11'd0,    randReady: 1'b0, expDone: 1};
        vecs[6] = '{base: 10'd1020, cnt: 11'd9,    randReady: 1'b1, expDone: -1};

        rst = 1'b1; start = 1'b0; baseAddr = '0; count = '0; ready = 1'b1;
        tick(); tick();
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset ren", memRen, 1'b0);
        checkOutput("reset addr", memAddr, 0);
        checkOutput("reset valid", valid, 1'b0);
        checkOutput("reset data", dataOut, 0);
        checkOutput("reset last", last, 1'b0);
        rst = 1'b0;
        tick();

        $display("[TB] wrap-around window");
        applyStimulus(10'd1022, 11'd4);
        sampleCycles(8, 0, 0);
        checkOutput("wrap valid cycles", vMask, 16'h0078);
        checkOutput("wrap last cycles", lMask, 16'h0040);
        checkOutput("wrap ren cycles", rMask, 16'h001E);
        checkOutput("wrap busy cycles", bMask, 16'h007E);
        checkOutput("wrap done cycles", dMask, 16'h0080);
        checkOutput("wrap lasts", lastCount, 1);

        $display("[TB] zero-count window");
        applyStimulus(10'd5, 11'd0);
        sampleCycles(3, 0, 0);
        checkOutput("zero done cycles", dMask, 16'h0002);
        checkOutput("zero busy cycles", bMask, 16'h0000);
        checkOutput("zero ren cycles", rMask, 16'h0000);
        checkOutput("zero valid cycles", vMask, 16'h0000);

        $display("[TB] backpressure window");
        ready = 1'b0;
        applyStimulus(10'd100, 11'd3);
        sampleCycles(12, 8, 0);
        checkOutput("bp ren cycles", rMask, 16'h0106);
        checkOutput("bp valid cycles", vMask, 16'h07F8);
        checkOutput("bp last cycles", lMask, 16'h0400);
        checkOutput("bp busy cycles", bMask, 16'h07FE);
        checkOutput("bp done cycles", dMask, 16'h0800);
        checkOutput("bp held data c3", dataLog[3], sampleAt(10'd100));
        checkOutput("bp held data c7", dataLog[7], sampleAt(10'd100));
        checkOutput("bp lasts", lastCount, 1);
        checkOutput("bp beats left", beatQ.size(), 0);

        $display("[TB] start while busy");
        applyStimulus(10'd200, 11'd6);
        sampleCycles(11, 0, 2);
        checkOutput("restart done cycles", dMask, 16'h0200);
        checkOutput("restart busy cycles", bMask, 16'h01FE);
        checkOutput("restart ren cycles", rMask, 16'h007E);
        checkOutput("restart lasts", lastCount, 1);
        checkOutput("restart beats left", beatQ.size(), 0);

        $display("[TB] reset mid-window");
        applyStimulus(10'd300, 11'd8);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addrQ.delete();
        beatQ.delete();
        checkOutput("midrst busy", busy, 1'b0);
        checkOutput("midrst done", done, 1'b0);
        checkOutput("midrst ren", memRen, 1'b0);
        checkOutput("midrst addr", memAddr, 0);
        checkOutput("midrst valid", valid, 1'b0);
        checkOutput("midrst data", dataOut, 0);
        checkOutput("midrst last", last, 1'b0);
        vMask = '0;
        for (int k = 0; k < 4; k++) begin
            vMask[k] = valid;
            tick();
        end
        checkOutput("midrst stale valid", vMask, 16'h0000);
        applyStimulus(10'd1020, 11'd5);
        sampleCycles(9, 0, 0);
        checkOutput("fresh done cycles", dMask, 16'h0100);
        checkOutput("fresh valid cycles", vMask, 16'h00F8);
        checkOutput("fresh lasts", lastCount, 1);

        $display("[TB] table-driven windows");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].base, vecs[i].cnt);
            runWindow(vecs[i].cnt, vecs[i].randReady, vecs[i].expDone);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
